mips_state_ctrl: RTL and testbench
==================================

# mips_state_ctrl

Multi-cycle sequencer for the MIPS CPU core. It walks each instruction through fetch, decode, execute, memory and writeback. It drives the 3-bit `state` bus consumed by `alu_control`, plus `alu_en` and the enables for `alu`, the instruction register, PC, register file and HI/LO. It owns the memory-bus handshake (`waitrequest`), holds EXEC for a fixed number of cycles for multiply/divide, and halts the core when execution reaches address 0.

## Interface
- MD_CYCLES, 4, EXEC length in cycles for MULT/MULTU/DIV/DIVU (legal range 1..15).
- clk  input  1  core clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- opcode  input  6  instruction [31:26], taken from the instruction register.
- funccode  input  6  instruction [5:0].
- rt_code  input  5  instruction [20:16]; used only when opcode=000001 (REGIMM).
- waitrequest  input  1  memory bus stall; the transfer completes on an edge where it is 0.
- pc_is_zero  input  1  PC equals 0x00000000.
- state  output  3  1=FETCH, 2=DECODE, 3=EXEC, 4=MEM, 5=WB, 0=HALTED.
- alu_en  output  1  ALU result register enable.
- mem_read / mem_write  output  1 each  bus read / write request.
- ir_write  output  1  latch instruction register.
- pc_write  output  1  update PC (next-PC mux is owned by the datapath).
- reg_write  output  1  register file write.
- hi_lo_write  output  1  HI/LO write.
- active  output  1  low only in HALTED.

## Operation
- Reset state: state=FETCH, counter=0, active=1. All other outputs are 0 during reset.
- All outputs are Moore outputs, decoded from state, the counter and the instruction class. There are no combinational paths from `waitrequest` to outputs, except `ir_write`.

Instruction classes:
- LOAD: opcode 100000–100110 except 100111.
- STORE: opcode 101000, 101001, 101011.
- MD: opcode 0 with funccode 011000–011011.
- HL: opcode 0 with funccode 010001 (MTHI) or 010011 (MTLO).
- NOWB: opcodes 000100–000111 and 000010; opcode 0 with funccode 001000 (JR); REGIMM with rt_code[4]=0.
- LINK: opcode 000011 (JAL); funccode 001001 (JALR); REGIMM with rt_code[4]=1.
- ALU: opcode 0 with any other funccode; opcodes 001001–001111.
- Anything else is ILLEGAL.

State behaviour:
- FETCH
  - If pc_is_zero=1: go to HALTED; no bus request.
  - Otherwise assert mem_read and stay while waitrequest=1.
  - When waitrequest=0: ir_write=1, then go to DECODE.
- DECODE: one cycle, then EXEC.
  - If class is MD, load the counter with MD_CYCLES-1; otherwise load 0.
- EXEC
  - alu_en=1 throughout.
  - While counter≠0, decrement and stay.
  - Final cycle (counter=0):
    - pc_write=1.
    - hi_lo_write=1 if class is MD or HL.
    - Next state: MEM for LOAD/STORE; WB for ALU/LINK; FETCH for MD/HL/NOWB/ILLEGAL.
- MEM
  - LOAD asserts mem_read; STORE asserts mem_write.
  - Stay while waitrequest=1.
  - When waitrequest=0: LOAD goes to WB, STORE goes to FETCH.
- WB: reg_write=1 for one cycle, then FETCH.
- HALTED: sticky until reset; all enables 0, active=0.
- Unused encodings 6 and 7 go to HALTED on the next edge.

## Timing
- Minimum cycles per instruction, with no wait states:
  - ALU/LINK: 4.
  - NOWB/HL/ILLEGAL: 3.
  - STORE: 4.
  - LOAD: 5.
  - MD: 2+MD_CYCLES.
- Each cycle with waitrequest=1 adds one cycle in FETCH or MEM.
- mem_read and mem_write are never asserted together. They stay asserted and stable from state entry until the completing edge.
- ir_write = (state==FETCH) & ~waitrequest & ~pc_is_zero.
- pc_write, hi_lo_write and reg_write are single-cycle pulses, each at most once per instruction.
- opcode, funccode and rt_code are sampled during DECODE, EXEC and MEM. The instruction register must stay stable from DECODE until the return to FETCH.
- Reset asserted mid-instruction, including during MEM with a request pending:
  - Request outputs drop in the same cycle.
  - state=FETCH on the first edge after reset is released.
- Halt check happens only in FETCH: an instruction whose pc_write sets PC to 0 completes, including WB, before the core halts.

## Test plan
- ADDU (opcode 0, funccode 100001), waitrequest=0 → state sequence 1,2,3,5,1; ir_write in cycle 1; alu_en in cycle 3; pc_write in cycle 3; reg_write in cycle 4.
- LW (100011) with waitrequest=1 for 2 cycles in FETCH and 3 cycles in MEM → mem_read held stable throughout; 10 cycles total; reg_write exactly once, after MEM completes.
- DIVU with MD_CYCLES=4 → EXEC for 4 cycles with alu_en=1; hi_lo_write and pc_write only in the 4th; then FETCH with reg_write never asserted.
- SW (101011) followed by BNE (000101) → mem_write in MEM only; BNE sequence 1,2,3,1 with no reg_write.
- JR to 0 (pc_is_zero rises after pc_write) → next FETCH goes to HALTED: active=0, mem_read never asserted, state stays 0 for 20 cycles.
- Reset pulse in MEM during LW with waitrequest=1 → mem_read=0 immediately; after release state=1 and active=1.

Source files
------------

// File: rtl/mips_state_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_state_ctrl_if
// Purpose  : Instruction fields, memory handshake and datapath enables
//            exchanged between the sequencer and the MIPS datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_state_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funccode;
    logic [4:0] rt_code;
    logic       waitrequest;
    logic       pc_is_zero;

    logic [2:0] state;
    logic       alu_en;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       hi_lo_write;
    logic       active;

    modport master (
        input  opcode, funccode, rt_code, waitrequest, pc_is_zero,
        output state, alu_en, mem_read, mem_write, ir_write,
               pc_write, reg_write, hi_lo_write, active
    );

    modport slave (
        output opcode, funccode, rt_code, waitrequest, pc_is_zero,
        input  state, alu_en, mem_read, mem_write, ir_write,
               pc_write, reg_write, hi_lo_write, active
    );
endinterface
`default_nettype wire

// File: rtl/mips_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_state_ctrl
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with bus stall
//            handling, multi-cycle multiply/divide and halt-at-address-0.
// Revision : 1.0 - initial release
// ============================================================================
module mips_state_ctrl #(
    parameter int MD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    mips_state_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_HALTED = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [3:0] C_MD_LOAD = 4'(MD_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_count;
    logic [3:0] w_count_next;

    logic w_load, w_store, w_md, w_hl, w_nowb, w_link, w_alu;
    logic w_rtype, w_regimm, w_jr, w_jalr;

    logic w_alu_en, w_mem_read, w_mem_write, w_ir_write;
    logic w_pc_write, w_reg_write, w_hi_lo_write, w_active;

    logic w_unused;
    assign w_unused = &{1'b0, bus.rt_code[3:0]};

    always_comb begin
        w_rtype  = (bus.opcode == 6'b000000);
        w_regimm = (bus.opcode == 6'b000001);
        w_jr     = w_rtype && (bus.funccode == 6'b001000);
        w_jalr   = w_rtype && (bus.funccode == 6'b001001);
        w_load   = (bus.opcode[5:3] == 3'b100) && (bus.opcode != 6'b100111);
        w_store  = (bus.opcode == 6'b101000) || (bus.opcode == 6'b101001) ||
                   (bus.opcode == 6'b101011);
        w_md     = w_rtype && (bus.funccode[5:2] == 4'b0110);
        w_hl     = w_rtype && ((bus.funccode == 6'b010001) ||
                               (bus.funccode == 6'b010011));
        w_nowb   = (bus.opcode[5:2] == 4'b0001) || (bus.opcode == 6'b000010) ||
                   w_jr || (w_regimm && !bus.rt_code[4]);
        w_link   = (bus.opcode == 6'b000011) || w_jalr ||
                   (w_regimm && bus.rt_code[4]);
        w_alu    = (w_rtype && !w_md && !w_hl && !w_jr && !w_jalr) ||
                   ((bus.opcode[5:3] == 3'b001) && (bus.opcode != 6'b001000));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_count <= 4'd0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_count_next  = r_count;
        w_alu_en      = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_hi_lo_write = 1'b0;
        w_active      = 1'b1;

        case (r_state)
            S_FETCH: begin
                if (bus.pc_is_zero) begin
                    w_next = S_HALTED;
                end else begin
                    w_mem_read = 1'b1;
                    if (!bus.waitrequest) begin
                        w_ir_write = 1'b1;
                        w_next     = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                w_count_next = w_md ? C_MD_LOAD : 4'd0;
                w_next       = S_EXEC;
            end
            S_EXEC: begin
                w_alu_en = 1'b1;
                if (r_count != 4'd0) begin
                    w_count_next = r_count - 4'd1;
                end else begin
                    w_pc_write    = 1'b1;
                    w_hi_lo_write = w_md || w_hl;
                    if (w_load || w_store)
                        w_next = S_MEM;
                    else if (w_alu || w_link)
                        w_next = S_WB;
                    else
                        w_next = S_FETCH;
                end
            end
            S_MEM: begin
                w_mem_read  = w_load;
                w_mem_write = w_store && !w_load;
                if (!bus.waitrequest)
                    w_next = w_load ? S_WB : S_FETCH;
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALTED: begin
                w_active = 1'b0;
            end
            default: begin
                w_next = S_HALTED;
            end
        endcase
    end

    // Reset masks every enable at once so a pending bus request drops before the clock.
    assign bus.state       = r_state;
    assign bus.active      = w_active;
    assign bus.alu_en      = w_alu_en      & ~reset;
    assign bus.mem_read    = w_mem_read    & ~reset;
    assign bus.mem_write   = w_mem_write   & ~reset;
    assign bus.ir_write    = w_ir_write    & ~reset;
    assign bus.pc_write    = w_pc_write    & ~reset;
    assign bus.reg_write   = w_reg_write   & ~reset;
    assign bus.hi_lo_write = w_hi_lo_write & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_mips_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_state_ctrl
// Purpose  : Self-checking bench: directed instruction table, halt and reset
//            corner cases, then random instructions against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_state_ctrl;

    localparam int MD = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_state_ctrl_if bus ();

    mips_state_ctrl #(.MD_CYCLES(MD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {K_LOAD, K_STORE, K_MD, K_HL, K_NOWB, K_LINK, K_ALU, K_ILL} kind_t;

    // One expected cycle: {state, active, mem_read, mem_write, ir_write,
    // alu_en, pc_write, reg_write, hi_lo_write} plus the waitrequest to drive.
    typedef struct packed {
        logic [2:0] st;
        logic act, mr, mw, ir, alu, pcw, rw, hl;
        logic wr;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        int fw, mw;
        int exp_cyc, exp_rw, exp_hl, exp_mwr;
    } vec_t;

    cyc_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [10:0] get_obs();
        return {bus.state, bus.active, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.alu_en, bus.pc_write, bus.reg_write, bus.hi_lo_write};
    endfunction

    task automatic check_vec(input logic [10:0] got, input logic [10:0] exp, input string name);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got st/act/mr/mw/ir/alu/pcw/rw/hl=%b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input int got, input int exp, input string name);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic kind_t classify(logic [5:0] op, logic [5:0] fn, logic [4:0] rt);
        if (op == 6'b000000) begin
            case (fn) inside
                [6'b011000:6'b011011]:   return K_MD;
                6'b010001, 6'b010011:    return K_HL;
                6'b001000:               return K_NOWB;
                6'b001001:               return K_LINK;
                default:                 return K_ALU;
            endcase
        end
        case (op) inside
            [6'b100000:6'b100110]:           return K_LOAD;
            6'b101000, 6'b101001, 6'b101011: return K_STORE;
            [6'b000100:6'b000111], 6'b000010: return K_NOWB;
            6'b000011:                       return K_LINK;
            6'b000001:                       return rt[4] ? K_LINK : K_NOWB;
            [6'b001001:6'b001111]:           return K_ALU;
            default:                         return K_ILL;
        endcase
    endfunction

    function automatic cyc_t mk(input logic [2:0] st, input logic mr, mw, ir, alu, pcw, rw, hl, wr);
        cyc_t c;
        c = '{st: st, act: 1'b1, mr: mr, mw: mw, ir: ir, alu: alu, pcw: pcw, rw: rw, hl: hl, wr: wr};
        return c;
    endfunction

    // Expected per-cycle trace of one instruction, from FETCH to the return to FETCH.
    task automatic build(input kind_t k, input int fw, input int mw);
        int n;
        logic last;
        q.delete();
        for (int i = 0; i < fw; i++) q.push_back(mk(3'd1, 1, 0, 0, 0, 0, 0, 0, 1'b1));
        q.push_back(mk(3'd1, 1, 0, 1, 0, 0, 0, 0, 1'b0));
        q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1))));
        n = (k == K_MD) ? MD : 1;
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            q.push_back(mk(3'd3, 0, 0, 0, 1, last, 0, last && (k == K_MD || k == K_HL),
                           1'($urandom_range(0, 1))));
        end
        if (k == K_LOAD || k == K_STORE)
            for (int j = 0; j <= mw; j++)
                q.push_back(mk(3'd4, k == K_LOAD, k == K_STORE, 0, 0, 0, 0, 0, j < mw));
        if (k == K_LOAD || k == K_ALU || k == K_LINK)
            q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 1, 0, 1'($urandom_range(0, 1))));
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                             input int fw, input int mw, input string tag,
                             output int cyc, output int rwc, output int hlc, output int mwc);
        cyc = -1; rwc = 0; hlc = 0; mwc = 0;
        bus.opcode = op; bus.funccode = fn; bus.rt_code = rt; bus.pc_is_zero = 1'b0;
        build(classify(op, fn, rt), fw, mw);
        for (int i = 0; i < q.size(); i++) begin
            bus.waitrequest = q[i].wr;
            #1;
            check_vec(get_obs(), q[i][11:1], $sformatf("%s cyc%0d", tag, i));
            rwc += int'(bus.reg_write);
            hlc += int'(bus.hi_lo_write);
            mwc += int'(bus.mem_write);
            @(posedge clk);
            #1;
            if (cyc < 0 && i >= fw && bus.state == 3'd1) cyc = i + 1;
        end
    endtask

    vec_t tbl[17];
    int cyc, rwc, hlc, mwc;

    initial begin
        tbl[0]  = '{6'b000000, 6'b100001, 5'd0,  0, 0,  4, 1, 0, 0}; // ADDU
        tbl[1]  = '{6'b100011, 6'b000000, 5'd0,  2, 3, 10, 1, 0, 0}; // LW stalled
        tbl[2]  = '{6'b000000, 6'b011011, 5'd0,  0, 0,  6, 0, 1, 0}; // DIVU
        tbl[3]  = '{6'b101011, 6'b000000, 5'd0,  0, 0,  4, 0, 0, 1}; // SW
        tbl[4]  = '{6'b000101, 6'b000000, 5'd0,  0, 0,  3, 0, 0, 0}; // BNE
        tbl[5]  = '{6'b000000, 6'b010011, 5'd0,  0, 0,  3, 0, 1, 0}; // MTLO
        tbl[6]  = '{6'b000011, 6'b000000, 5'd0,  0, 0,  4, 1, 0, 0}; // JAL
        tbl[7]  = '{6'b001000, 6'b000000, 5'd0,  0, 0,  3, 0, 0, 0}; // illegal
        tbl[8]  = '{6'b000001, 6'b000000, 5'd16, 0, 0,  4, 1, 0, 0}; // BLTZAL
        tbl[9]  = '{6'b000001, 6'b000000, 5'd1,  0, 0,  3, 0, 0, 0}; // BGEZ
        tbl[10] = '{6'b100110, 6'b000000, 5'd0,  1, 1,  7, 1, 0, 0}; // LWR
        tbl[11] = '{6'b100111, 6'b000000, 5'd0,  0, 0,  3, 0, 0, 0}; // illegal
        tbl[12] = '{6'b001101, 6'b000000, 5'd0,  1, 0,  5, 1, 0, 0}; // ORI
        tbl[13] = '{6'b101000, 6'b000000, 5'd0,  0, 2,  6, 0, 0, 3}; // SB stalled
        tbl[14] = '{6'b000000, 6'b001001, 5'd0,  0, 0,  4, 1, 0, 0}; // JALR
        tbl[15] = '{6'b000000, 6'b011000, 5'd0,  1, 0,  7, 0, 1, 0}; // MULT
        tbl[16] = '{6'b110000, 6'b000000, 5'd0,  0, 0,  3, 0, 0, 0}; // illegal

        reset = 1'b1;
        bus.opcode = '0; bus.funccode = '0; bus.rt_code = '0;
        bus.waitrequest = 1'b0; bus.pc_is_zero = 1'b0;
        #2;
        check_vec(get_obs(), {3'd1, 1'b1, 7'b0}, "reset_state");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].fn, tbl[i].rt, tbl[i].fw, tbl[i].mw,
                      $sformatf("tbl%0d", i), cyc, rwc, hlc, mwc);
            check_int(cyc, tbl[i].exp_cyc, $sformatf("tbl%0d cycles", i));
            check_int(rwc, tbl[i].exp_rw,  $sformatf("tbl%0d reg_write", i));
            check_int(hlc, tbl[i].exp_hl,  $sformatf("tbl%0d hi_lo_write", i));
            check_int(mwc, tbl[i].exp_mwr, $sformatf("tbl%0d mem_write", i));
        end

        // JR to address 0: next FETCH halts and stays halted
        run_instr(6'b000000, 6'b001000, 5'd0, 0, 0, "jr0", cyc, rwc, hlc, mwc);
        bus.pc_is_zero = 1'b1;
        bus.waitrequest = 1'b0;
        #1 check_vec(get_obs(), {3'd1, 1'b1, 7'b0}, "halt_fetch");
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            bus.waitrequest = 1'($urandom_range(0, 1));
            #1 check_vec(get_obs(), {3'd0, 1'b0, 7'b0}, $sformatf("halted%0d", i));
            @(posedge clk);
            #1;
        end

        // Reset during a stalled LW read in MEM
        reset = 1'b1;
        #1 check_vec(get_obs(), {3'd1, 1'b1, 7'b0}, "reset_from_halt");
        @(posedge clk);
        #1 reset = 1'b0;
        bus.pc_is_zero = 1'b0;
        bus.opcode = 6'b100011;
        bus.waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.waitrequest = 1'b1;
        #1 check_vec(get_obs(), {3'd4, 1'b1, 1'b1, 6'b0}, "lw_in_mem");
        reset = 1'b1;
        #1 check_vec(get_obs(), {3'd1, 1'b1, 7'b0}, "reset_drops_read");
        @(posedge clk);
        #1 check_vec(get_obs(), {3'd1, 1'b1, 7'b0}, "reset_held");
        reset = 1'b0;
        @(posedge clk);
        #1 check_vec(get_obs(), {3'd1, 1'b1, 1'b1, 6'b0}, "after_release");

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            logic [4:0] rt;
            op = ($urandom_range(0, 2) == 0) ? 6'b000000 : 6'($urandom_range(0, 63));
            fn = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1)
                case ($urandom_range(0, 3))
                    0: fn = 6'b011000 + 6'($urandom_range(0, 3));
                    1: fn = 6'b010001;
                    2: fn = 6'b001000;
                    default: fn = 6'b001001;
                endcase
            rt = 5'($urandom_range(0, 31));
            run_instr(op, fn, rt, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      $sformatf("rnd%0d op=%b fn=%b", n, op, fn), cyc, rwc, hlc, mwc);
            check_int(cyc, q.size(), $sformatf("rnd%0d cycles", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
